// File: rtl/mips_md_pkg.sv
//------------------------------------------------------------------------------
// Module   : mips_md_pkg
// Purpose  : Shared definitions for the iterative multiply/divide unit:
//            md_op encodings, FSM state enum and the divide-by-zero LO value.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_md_pkg;

  // md_op encodings as issued by the execute stage
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Unit sequencing
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // LO value delivered by a divide with a zero divisor
  localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/md_sign_fix.sv
//------------------------------------------------------------------------------
// Module   : md_sign_fix
// Purpose  : Combinational two's-complement sign correction applied in the
//            FIX cycle. Takes unsigned result magnitudes plus sign flags and
//            returns the architectural HI/LO values.
// Ports    : mag_hi_i/mag_lo_i - magnitude (product or remainder:quotient)
//            is_div_i          - 1: divide result, 0: multiply result
//            neg_i             - product / quotient is negative
//            rneg_i            - remainder is negative (divide only)
//            hi_o/lo_o         - corrected HI/LO
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] mag_hi_i,
  input  logic [WIDTH-1:0] mag_lo_i,
  input  logic             is_div_i,
  input  logic             neg_i,
  input  logic             rneg_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] w_prod_neg;

  // Multiply negates the full double-width product as one value
  assign w_prod_neg = -{mag_hi_i, mag_lo_i};

  always_comb begin
    hi_o = mag_hi_i;
    lo_o = mag_lo_i;
    if (is_div_i) begin
      if (neg_i)  lo_o = -mag_lo_i;
      if (rneg_i) hi_o = -mag_hi_i;
    end else if (neg_i) begin
      hi_o = w_prod_neg[2*WIDTH-1:WIDTH];
      lo_o = w_prod_neg[WIDTH-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
//------------------------------------------------------------------------------
// Module   : mult_div_unit
// Purpose  : Iterative 32-step shift-add multiplier / restoring divider that
//            owns the architectural HI/LO registers of the execute stage.
// Ports    : clk, reset (async, active-high)
//            md_start/md_op/srca/srcb - operation issue
//            md_abort                 - cancel an operation in progress
//            hilo_we/hilo_wdata       - MTHI (bit1) / MTLO (bit0)
//            md_run                   - busy flag; hi/lo - HI/LO registers
// Config   : MD_ZERO_SKIP_EN - when defined, operations with a zero operand
//            (or a zero divisor) bypass the iteration and go straight to FIX.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_div_unit
  import mips_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             md_abort,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             md_run,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Multiply: {upper sum, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand for multiply, divisor magnitude for divide
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               w_is_div, w_signed;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_rem_ge;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

  assign w_is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign w_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign w_mag_a  = (w_signed && srca[WIDTH-1]) ? -srca : srca;
  assign w_mag_b  = (w_signed && srcb[WIDTH-1]) ? -srcb : srcb;

  // Multiply step: conditional add into the upper half, carry kept for the shift
  assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

  // Divide step: remainder shifted left with the next dividend bit; the
  // remainder is always below the divisor, so WIDTH+1 bits suffice and the
  // low WIDTH bits of the subtraction are exact whenever it is kept.
  assign w_rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign w_rem_ge  = (w_rem_sh >= {1'b0, opb_q});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - opb_q;

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .mag_hi_i (acc_q[2*WIDTH-1:WIDTH]),
    .mag_lo_i (acc_q[WIDTH-1:0]),
    .is_div_i (is_div_q),
    .neg_i    (neg_q),
    .rneg_i   (rneg_q),
    .hi_o     (w_fix_hi),
    .lo_o     (w_fix_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          if (!md_abort) begin
            is_div_d = w_is_div;
            neg_d    = w_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            rneg_d   = w_signed && w_is_div && srca[WIDTH-1];
            div0_d   = w_is_div && (srcb == '0);
            cnt_d    = '0;
            state_d  = MD_RUN;
            if (w_is_div) begin
              acc_d = {{WIDTH{1'b0}}, w_mag_a};
              opb_d = w_mag_b;
            end else begin
              acc_d = {{WIDTH{1'b0}}, w_mag_b};
              opb_d = w_mag_a;
            end
`ifdef MD_ZERO_SKIP_EN
            // Preload the final magnitudes so FIX produces the same result
            // the full iteration would have reached.
            if (w_is_div) begin
              if (srcb == '0) begin
                acc_d   = {w_mag_a, {WIDTH{1'b0}}};
                state_d = MD_FIX;
              end else if (srca == '0) begin
                acc_d   = '0;
                state_d = MD_FIX;
              end
            end else if ((srca == '0) || (srcb == '0)) begin
              acc_d   = '0;
              state_d = MD_FIX;
            end
`endif
          end
        end else begin
          if (hilo_we[1]) hi_d = hilo_wdata;
          if (hilo_we[0]) lo_d = hilo_wdata;
        end
      end

      MD_RUN: begin
        if (md_abort) begin
          state_d = MD_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = w_rem_ge ? {w_rem_sub, acc_q[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = MD_FIX;
        end
      end

      MD_FIX: begin
        state_d = MD_IDLE;
        if (!md_abort) begin
          hi_d = w_fix_hi;
          lo_d = div0_q ? WIDTH'(MD_DIV0_LO) : w_fix_lo;
        end
      end

      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign md_run = (state_q != MD_IDLE);
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_mult_div_unit
// Purpose  : Self-checking bench for mult_div_unit: directed vector table,
//            randomized operations against an arithmetic reference model,
//            and hand-written busy / abort / MTHI-MTLO / reset sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] srca, srcb;
  logic        md_abort;
  logic [1:0]  hilo_we;
  logic [31:0] hilo_wdata;
  logic        md_run;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .md_start   (md_start),
    .md_op      (md_op),
    .srca       (srca),
    .srcb       (srcb),
    .md_abort   (md_abort),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata),
    .md_run     (md_run),
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain 64-bit math, truncating signed division
  task automatic ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rhi, output logic [31:0] rlo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); rhi = p[63:32]; rlo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; rhi = p[63:32]; rlo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin rhi = a; rlo = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; rhi = r[31:0]; rlo = q[31:0]; end
      end
      default: begin
        if (b == 0) begin rhi = a; rlo = 32'hFFFF_FFFF; end
        else begin rhi = a % b; rlo = a / b; end
      end
    endcase
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MD_ZERO_SKIP_EN
    if ((a == 0) || (b == 0)) return 1;
`endif
    return 33;
  endfunction

  // Issue one operation and count md_run cycles. inj_kind 1 = start+MTHI
  // while busy, 2 = abort; applied for one cycle at busy cycle inj_at.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] start_we, input int inj_at, input int inj_kind,
                        output int cyc, output bit held);
    logic [31:0] h0, l0;
    h0 = hi;
    l0 = lo;
    @(negedge clk);
    md_start = 1'b1; md_op = op; srca = a; srcb = b;
    hilo_we = start_we; hilo_wdata = 32'hFFFF_0000;
    @(negedge clk);
    md_start = 1'b0; hilo_we = 2'b00;
    srca = $urandom; srcb = $urandom;
    cyc  = 0;
    held = 1'b1;
    while (md_run && cyc < 200) begin
      cyc++;
      if ((hi !== h0) || (lo !== l0)) held = 1'b0;
      if (cyc == inj_at) begin
        if (inj_kind == 1) begin
          md_start = 1'b1; md_op = 2'b00;
          hilo_we = 2'b10; hilo_wdata = 32'hDEAD_BEEF;
        end else if (inj_kind == 2) begin
          md_abort = 1'b1;
        end
      end
      @(negedge clk);
      md_start = 1'b0; md_abort = 1'b0; hilo_we = 2'b00;
    end
  endtask

  vec_t        vecs[9];
  int          cyc;
  bit          held;
  logic [31:0] rhi, rlo, ph, pl;
  logic [1:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b1; md_start = 1'b0; md_op = 2'b00; srca = '0; srcb = '0;
    md_abort = 1'b0; hilo_we = 2'b00; hilo_wdata = '0;

    vecs[0] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[5] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{2'b00, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[8] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};

    repeat (3) @(negedge clk);
    check("reset_md_run", {31'b0, md_run}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 2'b00, 0, 0, cyc, held);
      check($sformatf("vec%0d_latency", i), cyc, exp_lat(vecs[i].op, vecs[i].a, vecs[i].b));
      check($sformatf("vec%0d_hold", i), {31'b0, held}, 32'd1);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'($urandom_range(0, 15));
        1: ra = 32'($urandom_range(0, 15));
        2: rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      ref_md(rop, ra, rb, rhi, rlo);
      run_op(rop, ra, rb, 2'b00, 0, 0, cyc, held);
      check($sformatf("rnd%0d_latency", n), cyc, exp_lat(rop, ra, rb));
      check($sformatf("rnd%0d_hi op=%0d a=%h b=%h", n, rop, ra, rb), hi, rhi);
      check($sformatf("rnd%0d_lo op=%0d a=%h b=%h", n, rop, ra, rb), lo, rlo);
    end

    // Start and MTHI while busy are both ignored
    run_op(2'b11, 32'd100, 32'd7, 2'b00, 10, 1, cyc, held);
    check("busy_latency", cyc, 32'd33);
    check("busy_hold", {31'b0, held}, 32'd1);
    check("busy_hi", hi, 32'd2);
    check("busy_lo", lo, 32'd14);

    // Abort in RUN: busy drops on the next cycle, HI/LO unchanged
    hilo_we = 2'b11; hilo_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    hilo_we = 2'b00;
    run_op(2'b11, 32'd100, 32'd7, 2'b00, 5, 2, cyc, held);
    check("abort_run_latency", cyc, 32'd5);
    check("abort_run_hi", hi, 32'h0BAD_F00D);
    check("abort_run_lo", lo, 32'h0BAD_F00D);

    // Abort in the final (FIX) cycle suppresses the write
    run_op(2'b11, 32'd100, 32'd9, 2'b00, 33, 2, cyc, held);
    check("abort_fix_latency", cyc, 32'd33);
    check("abort_fix_hi", hi, 32'h0BAD_F00D);
    check("abort_fix_lo", lo, 32'h0BAD_F00D);

    // MTLO then MTHI+MTLO in IDLE
    hilo_we = 2'b01; hilo_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hilo_we = 2'b00;
    check("mtlo_lo", lo, 32'hA5A5_A5A5);
    check("mtlo_hi", hi, 32'h0BAD_F00D);
    hilo_we = 2'b11; hilo_wdata = 32'h1122_3344;
    @(negedge clk);
    hilo_we = 2'b00;
    check("mthilo_hi", hi, 32'h1122_3344);
    check("mthilo_lo", lo, 32'h1122_3344);

    // hilo_we coincident with start: start wins, HI/LO untouched until FIX
    run_op(2'b11, 32'd100, 32'd7, 2'b11, 0, 0, cyc, held);
    check("start_we_hold", {31'b0, held}, 32'd1);
    check("start_we_lo", lo, 32'd14);

    // Abort in IDLE blocks the start
    ph = hi; pl = lo;
    @(negedge clk);
    md_start = 1'b1; md_abort = 1'b1; md_op = 2'b01; srca = 32'd3; srcb = 32'd5;
    @(negedge clk);
    md_start = 1'b0; md_abort = 1'b0;
    check("idle_abort_md_run", {31'b0, md_run}, 32'd0);
    @(negedge clk);
    check("idle_abort_lo", lo, pl);

    // Asynchronous reset mid-operation
    @(negedge clk);
    md_start = 1'b1; md_op = 2'b01; srca = 32'd3; srcb = 32'd5;
    @(negedge clk);
    md_start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_md_run", {31'b0, md_run}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_md_run", {31'b0, md_run}, 32'd0);
    check("async_reset_hi", hi, 32'd0);
    check("async_reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b01, 32'd3, 32'd5, 2'b00, 0, 0, cyc, held);
    check("post_reset_lo", lo, 32'd15);
    check("post_reset_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
